// File: rtl/pt_walk_arbiter.sv
// pt_walk_arbiter: round-robin arbiter sharing one page-table lookup port between two TLB miss requesters, with walk timeout.
// Ports: clk, rst_n (sync, active-low); RQST0/1 + LOOKUP0/1 from requesters;
// COMPLETE0/1, RECV0/1, FAULT0/1 back to requesters; PT_RQST/PT_LOOKUP to and
// PT_RECV/PT_COMPLETE from the page table; BUSY, GRANT_ID, FAULT_CNT status.
module pt_walk_arbiter #(
  parameter int TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RQST0,
  input  logic       RQST1,
  input  logic [4:0] LOOKUP0,
  input  logic [4:0] LOOKUP1,
  output logic       COMPLETE0,
  output logic       COMPLETE1,
  output logic [9:0] RECV0,
  output logic [9:0] RECV1,
  output logic       FAULT0,
  output logic       FAULT1,
  output logic       PT_RQST,
  output logic [4:0] PT_LOOKUP,
  input  logic [9:0] PT_RECV,
  input  logic       PT_COMPLETE,
  output logic       BUSY,
  output logic       GRANT_ID,
  output logic [7:0] FAULT_CNT
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP, ABORT} state_t;
  typedef struct packed {
    state_t     state;
    logic [7:0] cnt;
    logic       ptr;
    logic       grant;
    logic       pt_rqst;
    logic [4:0] pt_lookup;
    logic       complete0;
    logic       complete1;
    logic       fault0;
    logic       fault1;
    logic [9:0] recv0;
    logic [9:0] recv1;
    logic [7:0] fault_cnt;
    logic       busy;
  } regs_t;
  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);
  regs_t r, n;
  logic pick;
  // On a tie the requester that did not win last time gets the port.
  assign pick = (RQST0 & RQST1) ? ~r.ptr : RQST1;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r <= '0;
      r.ptr <= 1'b1;
    end else r <= n;
  end
  always_comb begin
    n = r;
    n.complete0 = 1'b0;
    n.complete1 = 1'b0;
    n.fault0 = 1'b0;
    n.fault1 = 1'b0;
    case (r.state)
      IDLE: if (RQST0 | RQST1) begin
        n.state = WAIT;
        n.grant = pick;
        n.ptr = pick;
        n.pt_rqst = 1'b1;
        n.pt_lookup = pick ? LOOKUP1 : LOOKUP0;
        n.cnt = '0;
      end
      // Completion is tested first so it wins over a coincident timeout.
      WAIT: if (PT_COMPLETE) begin
        n.state = RESP;
        n.pt_rqst = 1'b0;
        n.pt_lookup = '0;
        n.complete0 = ~r.grant;
        n.complete1 = r.grant;
        n.recv0 = r.grant ? r.recv0 : PT_RECV;
        n.recv1 = r.grant ? PT_RECV : r.recv1;
      end else if (r.cnt == LAST) begin
        n.state = ABORT;
        n.pt_rqst = 1'b0;
        n.pt_lookup = '0;
        n.fault0 = ~r.grant;
        n.fault1 = r.grant;
        n.fault_cnt = r.fault_cnt + {7'd0, ~&r.fault_cnt};
      end else n.cnt = r.cnt + 8'd1;
      default: n.state = IDLE;
    endcase
    n.busy = n.state != IDLE;
  end
  assign COMPLETE0 = r.complete0;
  assign COMPLETE1 = r.complete1;
  assign RECV0 = r.recv0;
  assign RECV1 = r.recv1;
  assign FAULT0 = r.fault0;
  assign FAULT1 = r.fault1;
  assign PT_RQST = r.pt_rqst;
  assign PT_LOOKUP = r.pt_lookup;
  assign BUSY = r.busy;
  assign GRANT_ID = r.grant;
  assign FAULT_CNT = r.fault_cnt;
endmodule

// File: tb/tb_pt_walk_arbiter.sv
// tb_pt_walk_arbiter: self-checking bench for pt_walk_arbiter using a vector table, hand sequences and randomized walks against a transaction-level model.
module tb_pt_walk_arbiter;
  localparam int T = 4;
  logic clk = 1'b0, rst_n = 1'b0;
  logic RQST0 = 1'b0, RQST1 = 1'b0, PT_COMPLETE = 1'b0;
  logic [4:0] LOOKUP0 = '0, LOOKUP1 = '0, PT_LOOKUP;
  logic [9:0] PT_RECV = '0, RECV0, RECV1;
  logic COMPLETE0, COMPLETE1, FAULT0, FAULT1, PT_RQST, BUSY, GRANT_ID;
  logic [7:0] FAULT_CNT;
  int vectors = 0, miscompares = 0;
  logic last;
  int fcnt;
  logic [9:0] exp_recv [2];
  logic [1:0] rr;
  logic g;
  typedef struct {
    logic r0, r1;
    logic [4:0] l0, l1;
    int d;
    logic [9:0] data;
    logic g;
  } vec_t;
  vec_t tbl [6];
  pt_walk_arbiter #(.TIMEOUT(T)) dut (
    .clk(clk), .rst_n(rst_n), .RQST0(RQST0), .RQST1(RQST1),
    .LOOKUP0(LOOKUP0), .LOOKUP1(LOOKUP1), .COMPLETE0(COMPLETE0), .COMPLETE1(COMPLETE1),
    .RECV0(RECV0), .RECV1(RECV1), .FAULT0(FAULT0), .FAULT1(FAULT1),
    .PT_RQST(PT_RQST), .PT_LOOKUP(PT_LOOKUP), .PT_RECV(PT_RECV), .PT_COMPLETE(PT_COMPLETE),
    .BUSY(BUSY), .GRANT_ID(GRANT_ID), .FAULT_CNT(FAULT_CNT)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // One walk: d is the PT_RQST-high cycle in which the page table completes;
  // d > T means it never completes and the walk must time out.
  task automatic walk(input logic r0, input logic r1, input logic [4:0] l0, input logic [4:0] l1,
                      input int d, input logic [9:0] data, input logic eg);
    int h;
    logic ok;
    ok = d <= T;
    RQST0 = r0; RQST1 = r1; LOOKUP0 = l0; LOOKUP1 = l1;
    step();
    check("grant_rqst", 32'(PT_RQST), 1);
    check("grant_id", 32'(GRANT_ID), 32'(eg));
    check("pt_lookup", 32'(PT_LOOKUP), 32'(eg ? l1 : l0));
    check("busy", 32'(BUSY), 1);
    last = eg;
    h = 1;
    for (int n = 0; n < T + 3 && !(COMPLETE0 | COMPLETE1 | FAULT0 | FAULT1); n++) begin
      PT_COMPLETE = (h == d);
      PT_RECV = (h == d) ? data : 10'($urandom);
      step();
      PT_COMPLETE = 1'b0;
      if (PT_RQST) h++;
    end
    if (ok) exp_recv[eg] = data;
    else if (fcnt != 255) fcnt++;
    check("high_cycles", 32'(h), 32'(ok ? d : T));
    check("complete", 32'({COMPLETE1, COMPLETE0}), ok ? (eg ? 2 : 1) : 0);
    check("fault", 32'({FAULT1, FAULT0}), ok ? 0 : (eg ? 2 : 1));
    check("recv0", 32'(RECV0), 32'(exp_recv[0]));
    check("recv1", 32'(RECV1), 32'(exp_recv[1]));
    check("fault_cnt", 32'(FAULT_CNT), 32'(fcnt));
    check("pt_idle", 32'({PT_RQST, PT_LOOKUP}), 0);
    RQST0 = 1'b0; RQST1 = 1'b0;
    step();
    check("idle_pulses", 32'({BUSY, COMPLETE1, COMPLETE0, FAULT1, FAULT0}), 0);
    check("grant_hold", 32'(GRANT_ID), 32'(eg));
  endtask
  initial begin
    tbl[0] = '{1'b1, 1'b1, 5'h03, 5'h1C, 2, 10'h2A5, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 5'h03, 5'h1C, 1, 10'h0F3, 1'b1};
    tbl[2] = '{1'b1, 1'b1, 5'h07, 5'h18, 3, 10'h155, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 5'h07, 5'h18, T, 10'h3C1, 1'b1};
    tbl[4] = '{1'b0, 1'b1, 5'h00, 5'h12, T + 1, 10'h111, 1'b1};
    tbl[5] = '{1'b1, 1'b0, 5'h0A, 5'h00, 1, 10'h14F, 1'b0};
    last = 1'b1; fcnt = 0; exp_recv[0] = '0; exp_recv[1] = '0;
    step();
    step();
    check("rst_outs", 32'({COMPLETE1, COMPLETE0, FAULT1, FAULT0, PT_RQST, BUSY, GRANT_ID}), 0);
    check("rst_data", 32'({PT_LOOKUP, FAULT_CNT}), 0);
    check("rst_recv", 32'({RECV1, RECV0}), 0);
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 6; i++) walk(tbl[i].r0, tbl[i].r1, tbl[i].l0, tbl[i].l1, tbl[i].d, tbl[i].data, tbl[i].g);
    for (int i = 0; i < 10; i++) begin
      step();
      check("recv0_hold", 32'(RECV0), 32'h14F);
      check("req1_quiet", 32'({COMPLETE1, FAULT1}), 0);
    end
    walk(1'b0, 1'b1, 5'h00, 5'h09, T + 1, 10'h000, 1'b1);
    PT_COMPLETE = 1'b1; PT_RECV = 10'h3FF;
    step();
    PT_COMPLETE = 1'b0;
    check("late_cmpl", 32'({BUSY, PT_RQST, COMPLETE1, COMPLETE0, FAULT1, FAULT0}), 0);
    check("late_recv", 32'({RECV1, RECV0}), 32'({exp_recv[1], exp_recv[0]}));
    check("late_fcnt", 32'(FAULT_CNT), 32'(fcnt));
    step();
    check("late_quiet", 32'({BUSY, COMPLETE1, COMPLETE0}), 0);
    RQST0 = 1'b1; LOOKUP0 = 5'h11;
    step();
    check("mid_grant", 32'({PT_RQST, GRANT_ID}), 32'b10);
    step();
    rst_n = 1'b0; RQST0 = 1'b0;
    step();
    check("mid_rst_outs", 32'({COMPLETE1, COMPLETE0, FAULT1, FAULT0, PT_RQST, BUSY, GRANT_ID}), 0);
    check("mid_rst_data", 32'({PT_LOOKUP, FAULT_CNT}), 0);
    check("mid_rst_recv", 32'({RECV1, RECV0}), 0);
    rst_n = 1'b1;
    last = 1'b1; fcnt = 0; exp_recv[0] = '0; exp_recv[1] = '0;
    step();
    check("mid_rst_quiet", 32'({COMPLETE1, COMPLETE0, FAULT1, FAULT0}), 0);
    walk(1'b1, 1'b1, 5'h05, 5'h1A, 2, 10'h2DD, 1'b0);
    for (int i = 0; i < 260; i++) walk(1'b1, 1'b0, 5'(i), 5'h00, T + 1, 10'h000, 1'b0);
    check("fault_sat", 32'(FAULT_CNT), 255);
    for (int i = 0; i < 200; i++) begin
      rr = 2'($urandom_range(1, 3));
      g = (rr[0] & rr[1]) ? ~last : rr[1];
      walk(rr[0], rr[1], 5'($urandom), 5'($urandom), $urandom_range(1, T + 2), 10'($urandom), g);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
